// File: rtl/router_pkg.sv
// Shared types and constants for the router packet source: FSM states,
// header layout and the header pack helper.
package router_pkg;

  localparam int unsigned HDR_LEN_W = 6;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned BYTE_W    = 8;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY
  } state_e;

  // Header byte as seen on the router input: length in the upper bits.
  typedef struct packed {
    logic [HDR_LEN_W-1:0] len;
    logic [ADDR_W-1:0]    addr;
  } hdr_t;

  function automatic hdr_t pack_header(input logic [HDR_LEN_W-1:0] len,
                                       input logic [ADDR_W-1:0]    addr);
    hdr_t h;
    h.len  = len;
    h.addr = addr;
    return h;
  endfunction

endpackage

// File: rtl/pkt_payload_buf.sv
// Store-and-forward payload buffer: one synchronous write port and one
// combinational read port; contents are never cleared.
module pkt_payload_buf #(
  parameter int unsigned DEPTH  = 63,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/router_pkt_source.sv
// Router packet source: buffers a payload, then sends header, payload and
// parity under busy backpressure. Optional feature macro: PARITY_CORRUPT_EN.
module router_pkt_source
  import router_pkg::*;
#(
  parameter int unsigned MAX_LEN = 63
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    dest_addr,
  input  logic [HDR_LEN_W-1:0] payload_len,
`ifdef PARITY_CORRUPT_EN
  input  logic                 corrupt_par,
`endif
  output logic                 req_ready,
  input  logic                 pay_valid,
  input  logic [BYTE_W-1:0]    pay_data,
  output logic                 pay_ready,
  input  logic                 busy,
  output logic [BYTE_W-1:0]    data_out,
  output logic                 pktvalid,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned BUF_AW = $clog2(MAX_LEN);
  localparam logic [HDR_LEN_W-1:0] MAX_LEN_V = HDR_LEN_W'(MAX_LEN);

  state_e               state_q, state_d;
  hdr_t                 hdr_q, hdr_d;
  logic [HDR_LEN_W-1:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0]    par_q, par_d;
  logic [BYTE_W-1:0]    data_q, data_d;
  logic                 pktvalid_q, pktvalid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 pay_ready_q, pay_ready_d;
  logic                 req_ready_q, req_ready_d;
  logic                 corrupt_q, corrupt_d;
  logic                 wr_en_c;
  logic                 last_c;
  logic [BUF_AW-1:0]    rd_idx_c;
  logic [BYTE_W-1:0]    rd_data_c;
  logic [BYTE_W-1:0]    par_out_c;

  pkt_payload_buf #(
    .DEPTH  (MAX_LEN),
    .DATA_W (BYTE_W)
  ) u_buf (
    .clk       (clk),
    .wr_en     (wr_en_c),
    .wr_addr   (BUF_AW'(cnt_q)),
    .wr_data   (pay_data),
    .rd_addr   (rd_idx_c),
    .rd_data_c (rd_data_c)
  );

  assign last_c = (cnt_q == (hdr_q.len - HDR_LEN_W'(1)));

  // Look-ahead read: the byte presented after the next accepted one.
  always_comb begin
    rd_idx_c = BUF_AW'(cnt_q + HDR_LEN_W'(1));
    if (state_q == ST_HEADER) begin
      rd_idx_c = '0;
    end
  end

`ifdef PARITY_CORRUPT_EN
  assign par_out_c = corrupt_q ? ~par_q : par_q;
`else
  assign par_out_c = par_q;
`endif

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    data_d      = data_q;
    pktvalid_d  = pktvalid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    pay_ready_d = pay_ready_q;
    req_ready_d = req_ready_q;
    corrupt_d   = corrupt_q;
    wr_en_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dest_addr == ADDR_INVALID || payload_len == '0 || payload_len > MAX_LEN_V) begin
            err_d = 1'b1;
          end else begin
            hdr_d       = pack_header(payload_len, dest_addr);
            par_d       = pack_header(payload_len, dest_addr);
            cnt_d       = '0;
            state_d     = ST_LOAD;
            pay_ready_d = 1'b1;
            req_ready_d = 1'b0;
`ifdef PARITY_CORRUPT_EN
            corrupt_d   = corrupt_par;
`else
            corrupt_d   = 1'b0;
`endif
          end
        end
      end

      ST_LOAD: begin
        if (pay_valid && pay_ready_q) begin
          wr_en_c = 1'b1;
          par_d   = par_q ^ pay_data;
          cnt_d   = cnt_q + HDR_LEN_W'(1);
          if (last_c) begin
            state_d     = ST_HEADER;
            pay_ready_d = 1'b0;
            data_d      = hdr_q;
            pktvalid_d  = 1'b1;
          end
        end
      end

      ST_HEADER: begin
        if (!busy) begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
          data_d  = rd_data_c;
        end
      end

      ST_PAYLOAD: begin
        if (!busy) begin
          if (last_c) begin
            state_d    = ST_PARITY;
            data_d     = par_out_c;
            pktvalid_d = 1'b0;
          end else begin
            cnt_d  = cnt_q + HDR_LEN_W'(1);
            data_d = rd_data_c;
          end
        end
      end

      ST_PARITY: begin
        if (!busy) begin
          state_d     = ST_IDLE;
          data_d      = '0;
          done_d      = 1'b1;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      cnt_q       <= '0;
      par_q       <= '0;
      data_q      <= '0;
      pktvalid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pay_ready_q <= 1'b0;
      req_ready_q <= 1'b1;
      corrupt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      data_q      <= data_d;
      pktvalid_q  <= pktvalid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pay_ready_q <= pay_ready_d;
      req_ready_q <= req_ready_d;
      corrupt_q   <= corrupt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign pay_ready = pay_ready_q;
  assign data_out  = data_q;
  assign pktvalid  = pktvalid_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_router_pkt_source.sv
// Scoreboard bench for router_pkt_source: expected bytes queued at request
// time, checked by an independent output monitor.
module tb_router_pkt_source;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = '0;
  logic [5:0] payload_len = '0;
  logic       pay_valid = 1'b0;
  logic [7:0] pay_data = '0;
  logic       busy = 1'b0;
  logic       req_ready, pay_ready, pktvalid, done, err;
  logic [7:0] data_out;
`ifdef PARITY_CORRUPT_EN
  logic       corrupt_par = 1'b0;
`endif

  router_pkt_source #(.MAX_LEN(63)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
`ifdef PARITY_CORRUPT_EN
    .corrupt_par (corrupt_par),
`endif
    .req_ready   (req_ready),
    .pay_valid   (pay_valid),
    .pay_data    (pay_data),
    .pay_ready   (pay_ready),
    .busy        (busy),
    .data_out    (data_out),
    .pktvalid    (pktvalid),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       pv;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pay_buf [64];
  int         checks = 0;
  int         errors = 0;
  int         pkt_cycles = 0;
  int         last_pkt_cycles = 0;
  bit         in_pkt = 0;
  bit         expect_done = 0;
  bit         hold_v = 0;
  logic [7:0] held_data;
  logic       held_pv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops one expected byte per accepted output byte.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      in_pkt      = 0;
      hold_v      = 0;
      expect_done = 0;
    end else begin
      if (expect_done) begin
        chk("done_pulse", 32'(done), 32'd1);
        expect_done = 0;
      end
      if (hold_v) begin
        chk("hold_data", 32'(data_out), 32'(held_data));
        chk("hold_pktvalid", 32'(pktvalid), 32'(held_pv));
        hold_v = 0;
      end
      if (!in_pkt && pktvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pktvalid", 32'(pktvalid), 32'd0);
        end else begin
          in_pkt     = 1;
          pkt_cycles = 0;
        end
      end
      if (in_pkt) begin
        pkt_cycles++;
        if (busy) begin
          hold_v    = 1;
          held_data = data_out;
          held_pv   = pktvalid;
        end else if (exp_q.size() == 0) begin
          chk("queue_underflow", 32'd1, 32'd0);
          in_pkt = 0;
        end else begin
          e = exp_q.pop_front();
          chk("out_byte", 32'(data_out), 32'(e.data));
          chk("out_pktvalid", 32'(pktvalid), 32'(e.pv));
          if (!e.pv) begin
            in_pkt          = 0;
            last_pkt_cycles = pkt_cycles;
            expect_done     = 1;
          end
        end
      end
    end
  end

  // Queue the expected packet, issue the request and feed the payload.
  task automatic send_pkt(input logic [1:0] a, input logic [5:0] len, input logic [7:0] hdr_exp,
                          input bit gaps, input bit corrupt);
    exp_t       e;
    logic [7:0] par;
    int         i;
    int         guard;
    bit         pv;
    bit         tog;
    logic       rdy;
    par    = hdr_exp;
    e.data = hdr_exp;
    e.pv   = 1'b1;
    exp_q.push_back(e);
    for (int k = 0; k < int'(len); k++) begin
      e.data = pay_buf[k];
      exp_q.push_back(e);
      par = par ^ pay_buf[k];
    end
    if (corrupt) par = ~par;
    e.data = par;
    e.pv   = 1'b0;
    exp_q.push_back(e);

    dest_addr   = a;
    payload_len = len;
`ifdef PARITY_CORRUPT_EN
    corrupt_par = corrupt;
`endif
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    i = 0;
    guard = 0;
    tog = 0;
    while (i < int'(len) && guard < 500) begin
      pv  = gaps ? !tog : 1'b1;
      tog = !tog;
      chk("no_hdr_during_load", 32'(pktvalid), 32'd0);
      pay_valid = pv;
      pay_data  = pay_buf[i];
      rdy       = pay_ready;
      @(posedge clk);
      #1;
      guard++;
      if (pv && rdy) i++;
    end
    pay_valid = 1'b0;
    chk("load_beats", 32'(i), 32'(len));
    chk("hdr_after_load", 32'(pktvalid), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= 400) chk("done_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_pktvalid", 32'(pktvalid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_pay_ready", 32'(pay_ready), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Packet addr=2 len=14, no stalls.
    for (int k = 0; k < 14; k++) pay_buf[k] = 8'(8'h10 + k * 8'h13);
    send_pkt(2'd2, 6'd14, 8'h3A, 1'b0, 1'b0);
    wait_done();
    chk("cycles_nostall", 32'(last_pkt_cycles), 32'd16);
    chk("req_ready_after", 32'(req_ready), 32'd1);

    // Same packet with stalls on header (3) and payload byte 5 (2).
    send_pkt(2'd2, 6'd14, 8'h3A, 1'b0, 1'b0);
    busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 busy = 1'b0;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 busy = 1'b1;
    repeat (2) @(posedge clk);
    #1 busy = 1'b0;
    wait_done();
    chk("cycles_stall", 32'(last_pkt_cycles), 32'd21);

    // Gappy upstream, len=4 addr=1.
    pay_buf[0] = 8'hA1; pay_buf[1] = 8'h00; pay_buf[2] = 8'hFF; pay_buf[3] = 8'h3C;
    send_pkt(2'd1, 6'd4, 8'h11, 1'b1, 1'b0);
    wait_done();

    // Invalid requests: bad address, then zero length.
    dest_addr = 2'd3; payload_len = 6'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("err_addr", 32'(err), 32'd1);
    chk("err_addr_req_ready", 32'(req_ready), 32'd1);
    chk("err_addr_pay_ready", 32'(pay_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("err_addr_pulse_end", 32'(err), 32'd0);
    dest_addr = 2'd1; payload_len = 6'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("err_len0", 32'(err), 32'd1);
    chk("err_len0_req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_no_pktvalid", 32'(pktvalid), 32'd0);

    // Reset while payload byte 7 of a len=20 packet is on the bus.
    for (int k = 0; k < 20; k++) pay_buf[k] = 8'(8'hC0 ^ k);
    send_pkt(2'd1, 6'd20, 8'h51, 1'b0, 1'b0);
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_byte7", 32'(data_out), 32'h00C7);
    #1 rst = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_pktvalid", 32'(pktvalid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    pay_buf[0] = 8'h9E;
    send_pkt(2'd0, 6'd1, 8'h04, 1'b0, 1'b0);
    wait_done();

`ifdef PARITY_CORRUPT_EN
    // Corrupted parity: expected parity byte is ~(0x04 ^ 0x55) = 0xAE.
    pay_buf[0] = 8'h55;
    send_pkt(2'd0, 6'd1, 8'h04, 1'b0, 1'b1);
    wait_done();
    send_pkt(2'd0, 6'd1, 8'h04, 1'b0, 1'b0);
    wait_done();
`else
    pay_buf[0] = 8'h55;
    send_pkt(2'd0, 6'd1, 8'h04, 1'b0, 1'b0);
    wait_done();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
